// File: rtl/pet_keyboard.sv
// PET keyboard matrix: Pi host loads 10 column bytes, 6502 selects a row via PIA1 port A and reads it on port B.
// Optional macro KBD_PORTA_READBACK_EN lets port A reads return {4'hF, row_sel}.
module pet_keyboard #(
  parameter logic [15:0] PI_BASE   = 16'hE800,
  parameter int          NUM_ROWS  = 10,
  parameter logic [7:0]  IDLE_COLS = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pi_addr,
  input  logic [7:0]  pi_data,
  input  logic        pi_write_strobe,
  input  logic [1:0]  bus_addr,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_rw_b,
  input  logic        io_read,
  input  logic        cpu_write_strobe,
  input  logic        pia1_enabled_in,
  output logic [7:0]  kbd_data_out,
  output logic        kbd_enable
);

  logic [7:0]  matrix [NUM_ROWS];
  logic [3:0]  row_sel;
  logic [15:0] pi_off;
  logic        pi_hit;
  logic        sel_wr;
  logic [7:0]  sel_cols;
  logic        port_b_rd;

  // The lower-bound test keeps addresses below PI_BASE from wrapping into range.
  assign pi_off = pi_addr - PI_BASE;
  assign pi_hit = pi_write_strobe && (pi_addr >= PI_BASE) && (pi_off < 16'(NUM_ROWS));
  assign sel_wr = cpu_write_strobe && pia1_enabled_in && !bus_rw_b && (bus_addr == 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROWS; i++) matrix[i] <= IDLE_COLS;
      row_sel <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        if (pi_hit && (pi_off == 16'(i))) matrix[i] <= pi_data;
      end
      if (sel_wr) row_sel <= bus_data_in[3:0];
    end
  end

  // Rows past the matrix read as "no key pressed".
  always_comb begin
    sel_cols = IDLE_COLS;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (row_sel == 4'(i)) sel_cols = matrix[i];
    end
  end

  assign port_b_rd = pia1_enabled_in && io_read && (bus_addr == 2'd2);

  always_comb begin
    kbd_enable   = 1'b0;
    kbd_data_out = 8'h00;
    if (port_b_rd) begin
      kbd_enable   = 1'b1;
      kbd_data_out = sel_cols;
    end
`ifdef KBD_PORTA_READBACK_EN
    if (pia1_enabled_in && io_read && (bus_addr == 2'd0)) begin
      kbd_enable   = 1'b1;
      kbd_data_out = {4'hF, row_sel};
    end
`else
`endif
  end

endmodule

// File: tb/tb_pet_keyboard.sv
// Randomized bench for pet_keyboard against an array-based model of the key matrix.
module tb_pet_keyboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pi_addr;
  logic [7:0]  pi_data;
  logic        pi_write_strobe;
  logic [1:0]  bus_addr;
  logic [7:0]  bus_data_in;
  logic        bus_rw_b;
  logic        io_read;
  logic        cpu_write_strobe;
  logic        pia1_enabled_in;
  logic [7:0]  kbd_data_out;
  logic        kbd_enable;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mat [10];
  int         m_sel;

  pet_keyboard dut (
    .clk              (clk),
    .reset            (reset),
    .pi_addr          (pi_addr),
    .pi_data          (pi_data),
    .pi_write_strobe  (pi_write_strobe),
    .bus_addr         (bus_addr),
    .bus_data_in      (bus_data_in),
    .bus_rw_b         (bus_rw_b),
    .io_read          (io_read),
    .cpu_write_strobe (cpu_write_strobe),
    .pia1_enabled_in  (pia1_enabled_in),
    .kbd_data_out     (kbd_data_out),
    .kbd_enable       (kbd_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_check(input string tag);
    logic       en;
    logic [7:0] d;
    en = pia1_enabled_in && io_read && (bus_addr == 2'd2);
    d  = 8'h00;
    if (en) d = (m_sel < 10) ? m_mat[m_sel] : 8'hFF;
`ifdef KBD_PORTA_READBACK_EN
    if (pia1_enabled_in && io_read && (bus_addr == 2'd0)) begin
      en = 1'b1;
      d  = {4'hF, 4'(m_sel)};
    end
`else
`endif
    check({tag, "_en"}, 16'(kbd_enable), 16'(en));
    check({tag, "_dat"}, 16'(kbd_data_out), 16'(d));
  endtask

  // Check reads against pre-edge state, then commit the cycle into the model.
  task automatic tick(input string tag);
    int a;
    #2 model_check(tag);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 10; i++) m_mat[i] = 8'hFF;
      m_sel = 0;
    end else begin
      a = int'(pi_addr) - 'hE800;
      if (pi_write_strobe && a >= 0 && a < 10) m_mat[a] = pi_data;
      if (cpu_write_strobe && pia1_enabled_in && !bus_rw_b && bus_addr == 2'd0)
        m_sel = int'(bus_data_in[3:0]);
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; pi_write_strobe = 0; cpu_write_strobe = 0;
    pia1_enabled_in = 0; io_read = 0; bus_rw_b = 1; bus_addr = 2'd1;
    pi_addr = 16'h0000; pi_data = 8'h00; bus_data_in = 8'h00;
  endtask

  task automatic sel_row(input logic [7:0] v);
    cpu_write_strobe = 1; pia1_enabled_in = 1; bus_rw_b = 0; io_read = 0;
    bus_addr = 2'd0; bus_data_in = v;
  endtask

  task automatic pi_wr(input logic [15:0] a, input logic [7:0] d);
    pi_write_strobe = 1; pi_addr = a; pi_data = d;
  endtask

  task automatic rd(input logic [1:0] ba);
    cpu_write_strobe = 0; pia1_enabled_in = 1; bus_rw_b = 1; io_read = 1; bus_addr = ba;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) m_mat[i] = 8'hFF;
    m_sel = 0;
    idle();
    reset = 1;
    @(posedge clk); #1;
    tick("rst");
    idle();

    rd(2'd2);
    check("rst_row0", 16'(kbd_data_out), 16'h00FF);
    tick("rst_rd");
    idle(); sel_row(8'h03); tick("sel3");
    idle(); rd(2'd2);
    check("row3_idle_en", 16'(kbd_enable), 16'h0001);
    check("row3_idle", 16'(kbd_data_out), 16'h00FF);
    tick("row3_rd");

    for (int r = 0; r < 10; r++) begin
      logic [7:0] v;
      v = 8'h01 << (r % 8);
      idle(); pi_wr(16'hE800 + 16'(r), v); sel_row(8'(r)); tick("wr_sel");
      idle(); rd(2'd2);
      check($sformatf("row%0d_val", r), 16'(kbd_data_out), 16'(v));
      tick("row_rd");
    end

    idle(); reset = 1; tick("rst2");
    idle(); pi_wr(16'hE80A, 8'h00); tick("wr_hi");
    idle(); pi_wr(16'hE7FF, 8'h00); tick("wr_lo");
    for (int r = 0; r < 10; r++) begin
      idle(); sel_row(8'(r)); tick("scan_sel");
      idle(); rd(2'd2); tick("scan_rd");
    end
    idle(); sel_row(8'h0C); tick("sel12");
    idle(); rd(2'd2);
    check("row12_idle", 16'(kbd_data_out), 16'h00FF);
    tick("row12_rd");

    idle(); pi_wr(16'hE805, 8'h5A); sel_row(8'hF5); tick("selF5");
    idle(); rd(2'd2);
    check("row5_nibble", 16'(kbd_data_out), 16'h005A);
    tick("row5_rd");
    idle(); sel_row(8'h02); pia1_enabled_in = 0; tick("sel_nocs");
    idle(); rd(2'd2);
    check("row5_kept", 16'(kbd_data_out), 16'h005A);
    tick("kept_rd");
    idle(); rd(2'd2); pia1_enabled_in = 0; #1;
    check("nocs_en", 16'(kbd_enable), 16'h0000);
    check("nocs_dat", 16'(kbd_data_out), 16'h0000);
    tick("nocs_rd");
    idle(); rd(2'd1);
    check("ba1_en", 16'(kbd_enable), 16'h0000);
    tick("ba1_rd");

    idle(); sel_row(8'h02); tick("sel2");
    idle(); pi_wr(16'hE802, 8'hAA); reset = 1; tick("wr_rst");
    idle(); sel_row(8'h02); tick("sel2b");
    idle(); rd(2'd2);
    check("row2_rst", 16'(kbd_data_out), 16'h00FF);
    tick("row2_rd");

    idle(); sel_row(8'h07); tick("sel7");
    idle(); rd(2'd0);
`ifdef KBD_PORTA_READBACK_EN
    check("pa_en", 16'(kbd_enable), 16'h0001);
    check("pa_dat", 16'(kbd_data_out), 16'h00F7);
`else
    check("pa_en", 16'(kbd_enable), 16'h0000);
    check("pa_dat", 16'(kbd_data_out), 16'h0000);
`endif
    tick("pa_rd");

    // Random traffic: overlapping Pi writes, row selects, reads and rare resets.
    for (int n = 0; n < 800; n++) begin
      reset            = ($urandom_range(0, 39) == 0);
      pi_write_strobe  = $urandom_range(0, 1) == 1;
      pi_addr          = 16'hE7FC + 16'($urandom_range(0, 17));
      pi_data          = 8'($urandom);
      cpu_write_strobe = $urandom_range(0, 1) == 1;
      pia1_enabled_in  = $urandom_range(0, 3) != 0;
      bus_rw_b         = $urandom_range(0, 1) == 1;
      io_read          = $urandom_range(0, 1) == 1;
      bus_addr         = 2'($urandom);
      bus_data_in      = 8'($urandom);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
